// File: rtl/demux_1_to_4_router.sv
// One-to-four word router: steers each source word to one of four channels,
// each with a one-entry holding register, a valid/ready handshake and a delivery counter.
module demux_1_to_4_router #(
  parameter int unsigned b  = 8,
  parameter int unsigned CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [b-1:0]      in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [b-1:0]      out_data0,
  output logic [b-1:0]      out_data1,
  output logic [b-1:0]      out_data2,
  output logic [b-1:0]      out_data3,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [4*CW-1:0]   xfer_cnt
);

  localparam int unsigned NCH = 4;

  logic [b-1:0]  data_q [NCH];
  logic [CW-1:0] cnt_q  [NCH];
  logic [NCH-1:0] valid_q;
  logic [NCH-1:0] load;
  logic [NCH-1:0] deliver;

  // A slot can take a word when it is empty or draining on this same edge.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];

  always_comb begin
    load    = '0;
    deliver = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k]    = in_valid & in_ready & (in_sel == 2'(k));
      deliver[k] = valid_q[k] & out_ready[k];
    end
  end

  // Per-channel holding register, valid flag and delivery counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (deliver[k]) begin
          valid_q[k] <= 1'b0;
        end
        if (deliver[k]) begin
          cnt_q[k] <= cnt_q[k] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    xfer_cnt = '0;
    for (int k = 0; k < NCH; k++) begin
      xfer_cnt[k*CW +: CW] = cnt_q[k];
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

endmodule

// File: doc/demux_1_to_4_router.md
Name: demux_1_to_4_router

Overview:
- Inverse of the 4-to-1 operand mux: takes one b-bit source stream and steers each word to one of four destination channels chosen by a 2-bit select.
- Each destination has a one-entry holding register with a valid/ready handshake, so a stalled destination never blocks the other three.
- Sits on the processor's result/writeback path, feeding up to four consumers (register-file ports, I/O latches).
- Per-channel delivered-word counters support debug and bring-up.

Parameters:
- b, 8, data width of input and each output channel.
- CW, 16, width of each per-channel transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  b  source word.
- in_sel  input  2  destination channel, 0..3.
- in_valid  input  1  source word present.
- in_ready  output  1  router can accept to channel in_sel this cycle.
- out_data0, out_data1, out_data2, out_data3  output  b each  holding-register contents per channel.
- out_valid  output  4  bit k = channel k holds an undelivered word.
- out_ready  input  4  bit k = consumer k accepts this cycle.
- xfer_cnt  output  4*CW  packed counters; bits [k*CW +: CW] belong to channel k.

Behaviour:
- Reset: while rst_n is low (asynchronous, takes effect immediately), out_valid = 0, out_data0..3 = 0, xfer_cnt = 0. Any word held at reset assertion is discarded.
- in_ready (combinational) = ~out_valid[in_sel] | out_ready[in_sel].
  - Depends only on the selected channel.
  - Defined even when in_valid = 0.
  - The combinational path out_ready -> in_ready is intended.
- Accept: if in_valid & in_ready at a rising edge, then out_data<in_sel> <= in_data and out_valid[in_sel] <= 1. Latency is 1 cycle from acceptance to out_valid.
- Deliver: channel k completes when out_valid[k] & out_ready[k] at a rising edge.
  - Without a same-edge load to k: out_valid[k] <= 0 and out_data<k> holds its old value.
  - With a same-edge load to k: out_valid[k] stays 1 and out_data<k> takes the new word. This gives full throughput of 1 word/cycle per channel.
- Stall: while out_valid[k] & ~out_ready[k], out_data<k> and out_valid[k] are stable and no word is accepted for k.
- Channels are independent. Loads to channel j and deliveries on other channels occur in the same cycle, so up to four deliveries plus one load per cycle.
- A word offered with in_valid=1 and in_ready=0 is not captured; the source holds it, with in_sel and in_data unchanged, until accepted.
- xfer_cnt[k] increments by 1 on each completed delivery on channel k and wraps modulo 2^CW, from 2^CW-1 to 0. Load events do not count.
- out_ready[k] asserted while out_valid[k]=0 has no effect.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with channel 1 holding 8'hAA -> out_valid=4'b0000, out_data1=0, xfer_cnt=0 immediately, without waiting for a clk edge.
- Routing:
  - Stimulus: out_ready=4'b1111; send 8'h01, 8'h02, 8'h03, 8'h04 with in_sel 0, 1, 2, 3 on consecutive cycles.
  - Response: each out_valid[k] is high for exactly one cycle, one cycle after its acceptance, with out_data<k> = k+1. in_ready stays 1 throughout. Every xfer_cnt field = 1.
- Backpressure:
  - Stimulus: out_ready[2]=0; send 8'h03 then 8'h33 to channel 2.
  - Response: 8'h03 is held; in_ready=0 while 8'h33 is offered and out_data2 stays 8'h03.
  - Stimulus: raise out_ready[2].
  - Response: 8'h03 is delivered and 8'h33 is loaded on the same edge, out_valid[2] stays 1, xfer_cnt[2]=1.
- Independence: channel 1 stalled holding 8'h11; send 8'h77 to channel 3 -> in_ready=1, accepted, out_data3=8'h77; channel 1 unchanged.
- Counter wrap: CW=4; complete 17 deliveries on channel 0 -> xfer_cnt[3:0]=4'h1, other counters 0.
